spi_board_arbiter: RTL and testbench

// - Shares the single on-board SPI bus (common COPI/SCLK/CIPO; one CS_N per device: flash, microSD)

---
 rtl/sonata_pkg.sv | 15 +
 rtl/spi_board_rr_pick.sv | 33 +++
 rtl/spi_board_arbiter.sv | 134 +++++++++++++
 tb/tb_spi_board_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sonata_pkg.sv
// Shared types and board-level constants for the sonata SPI board arbiter.
package sonata_pkg;

  // Board SPI arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_GAP   = 2'd2
  } spi_arb_state_e;

  // Requester index == board chip-select index.
  localparam int unsigned SpiBoardFlash   = 0;
  localparam int unsigned SpiBoardMicroSd = 1;

endpackage

// File: rtl/spi_board_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, searching cyclically.
module spi_board_rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] onehot_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // Walk requesters starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned w_j;
    logic        w_found;
    onehot_o = '0;
    idx_o    = '0;
    w_found  = 1'b0;
    w_j      = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      w_j = 32'(ptr_i) + k;
      if (w_j >= NumReq) w_j = w_j - NumReq;
      if (!w_found && req_i[IdxW'(w_j)]) begin
        w_found                 = 1'b1;
        idx_o                   = IdxW'(w_j);
        onehot_o[IdxW'(w_j)]    = 1'b1;
      end
    end
    valid_o = w_found;
  end

endmodule

// File: rtl/spi_board_arbiter.sv
// Shares the board SPI bus between NumReq host controllers, one CS-framed
// transaction per grant, round-robin, with an idle gap and optional watchdog.
module spi_board_arbiter
  import sonata_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned GapCycles     = 4,
  parameter int unsigned MaxHoldCycles = 0
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  input  logic [NumReq-1:0] copi_i,
  input  logic [NumReq-1:0] sclk_i,
  input  logic [NumReq-1:0] cs_ni,
  output logic [NumReq-1:0] cipo_o,
  output logic              spi_copi_o,
  output logic              spi_sclk_o,
  input  logic              spi_cipo_i,
  output logic [NumReq-1:0] spi_cs_no,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned HoldW = (MaxHoldCycles > 0) ? $clog2(MaxHoldCycles + 1) : 1;
  localparam int unsigned GapW  = $clog2(GapCycles + 1);

  localparam logic [HoldW-1:0] HoldMax  = HoldW'(MaxHoldCycles);
  localparam logic [HoldW-1:0] HoldLast = HoldW'((MaxHoldCycles == 0) ? 0 : MaxHoldCycles - 1);
  localparam logic [GapW-1:0]  GapMax   = GapW'(GapCycles);
  localparam logic [GapW-1:0]  GapLast  = GapW'(GapCycles - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumReq - 1);

  spi_arb_state_e    r_state;
  spi_arb_state_e    w_state_nxt;
  logic [IdxW-1:0]   r_owner;
  logic [IdxW-1:0]   r_ptr;
  logic [HoldW-1:0]  r_hold_cnt;
  logic [GapW-1:0]   r_gap_cnt;
  logic [NumReq-1:0] r_gnt;
  logic              r_timeout;

  logic [NumReq-1:0] w_pick_onehot;
  logic [IdxW-1:0]   w_pick_idx;
  logic              w_pick_valid;
  logic              w_release;
  logic              w_wd_fire;

  spi_board_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (r_ptr),
    .onehot_o (w_pick_onehot),
    .idx_o    (w_pick_idx),
    .valid_o  (w_pick_valid)
  );

  // Owner is done only once it has stopped requesting and its CS_N is high.
  assign w_release = !req_i[r_owner] && cs_ni[r_owner];
  assign w_wd_fire = (MaxHoldCycles != 0) && (r_state == ARB_OWNED) &&
                     !w_release && (r_hold_cnt == HoldLast);

  // State register.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) r_state <= ARB_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB_IDLE:  if (w_pick_valid)            w_state_nxt = ARB_OWNED;
      ARB_OWNED: if (w_release || w_wd_fire)  w_state_nxt = ARB_GAP;
      ARB_GAP:   if (r_gap_cnt == GapLast)    w_state_nxt = ARB_IDLE;
      default:                                w_state_nxt = ARB_IDLE;
    endcase
  end

  // Pin mux: only the registered owner reaches the board, and only while OWNED.
  always_comb begin
    spi_copi_o = 1'b1;
    spi_sclk_o = 1'b0;
    spi_cs_no  = '1;
    cipo_o     = '1;
    if (r_state == ARB_OWNED) begin
      spi_copi_o         = copi_i[r_owner];
      spi_sclk_o         = sclk_i[r_owner];
      spi_cs_no[r_owner] = cs_ni[r_owner];
      cipo_o[r_owner]    = spi_cipo_i;
    end
  end

  // Hold/gap counters: held at zero outside their state, saturating inside it.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (r_state != ARB_OWNED)    r_hold_cnt <= '0;
      else if (r_hold_cnt != HoldMax) r_hold_cnt <= r_hold_cnt + HoldW'(1);
      if (r_state != ARB_GAP)      r_gap_cnt <= '0;
      else if (r_gap_cnt != GapMax)   r_gap_cnt <= r_gap_cnt + GapW'(1);
    end
  end

  // Owner latch, grant, round-robin pointer and watchdog pulse.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_owner   <= '0;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_fire;
      if (r_state == ARB_IDLE && w_pick_valid) begin
        r_owner <= w_pick_idx;
        r_gnt   <= w_pick_onehot;
      end else if (r_state == ARB_OWNED && w_state_nxt == ARB_GAP) begin
        r_gnt <= '0;
        r_ptr <= (r_owner == IdxLast) ? '0 : r_owner + IdxW'(1);
      end
    end
  end

  assign gnt_o     = r_gnt;
  assign timeout_o = r_timeout;
  assign busy_o    = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_spi_board_arbiter.sv
// Directed bench for spi_board_arbiter: one instance without watchdog, one with.
module tb_spi_board_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: watchdog disabled.
  logic [1:0] a_req, a_gnt, a_copi, a_sclk, a_cs, a_cipo, a_pin_cs;
  logic       a_pin_copi, a_pin_sclk, a_pin_cipo, a_busy, a_timeout;

  // Instance B: watchdog at 16 cycles.
  logic [1:0] b_req, b_gnt, b_copi, b_sclk, b_cs, b_cipo, b_pin_cs;
  logic       b_pin_copi, b_pin_sclk, b_pin_cipo, b_busy, b_timeout;

  int total = 0;
  int bad   = 0;

  spi_board_arbiter #(.NumReq(2), .GapCycles(4), .MaxHoldCycles(0)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .req_i(a_req), .gnt_o(a_gnt),
    .copi_i(a_copi), .sclk_i(a_sclk), .cs_ni(a_cs), .cipo_o(a_cipo),
    .spi_copi_o(a_pin_copi), .spi_sclk_o(a_pin_sclk), .spi_cipo_i(a_pin_cipo),
    .spi_cs_no(a_pin_cs), .busy_o(a_busy), .timeout_o(a_timeout)
  );

  spi_board_arbiter #(.NumReq(2), .GapCycles(4), .MaxHoldCycles(16)) dut_wd (
    .clk_sys_i(clk), .rst_sys_i(rst), .req_i(b_req), .gnt_o(b_gnt),
    .copi_i(b_copi), .sclk_i(b_sclk), .cs_ni(b_cs), .cipo_o(b_cipo),
    .spi_copi_o(b_pin_copi), .spi_sclk_o(b_pin_sclk), .spi_cipo_i(b_pin_cipo),
    .spi_cs_no(b_pin_cs), .busy_o(b_busy), .timeout_o(b_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_req = 2'b00; a_copi = 2'b11; a_sclk = 2'b00; a_cs = 2'b11; a_pin_cipo = 1'b1;
    b_req = 2'b00; b_copi = 2'b11; b_sclk = 2'b00; b_cs = 2'b11; b_pin_cipo = 1'b1;
    rst = 1'b1;
    #12;
    total++; if (a_gnt !== 2'b00)  begin bad++; $display("FAIL reset_gnt got=%b exp=00", a_gnt); end
    total++; if (a_pin_cs !== 2'b11) begin bad++; $display("FAIL reset_cs got=%b exp=11", a_pin_cs); end
    total++; if ({a_pin_sclk, a_pin_copi} !== 2'b01) begin bad++; $display("FAIL reset_sclk_copi got=%b exp=01", {a_pin_sclk, a_pin_copi}); end
    total++; if ({a_cipo, a_busy, a_timeout} !== 4'b1100) begin bad++; $display("FAIL reset_cipo_busy_to got=%b exp=1100", {a_cipo, a_busy, a_timeout}); end
    #3 rst = 1'b0;
    tick();
    // Mid-transaction async reset.
    a_req = 2'b01;
    tick();
    total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL pre_rst_gnt got=%b exp=01", a_gnt); end
    a_cs = 2'b10; a_sclk = 2'b01; a_copi = 2'b10;
    #1;
    total++; if ({a_pin_cs, a_pin_sclk, a_pin_copi} !== 4'b1010) begin bad++; $display("FAIL pre_rst_pins got=%b exp=1010", {a_pin_cs, a_pin_sclk, a_pin_copi}); end
    #2 rst = 1'b1;
    #1;
    total++; if ({a_pin_cs, a_pin_sclk, a_pin_copi} !== 4'b1101) begin bad++; $display("FAIL async_rst_pins got=%b exp=1101", {a_pin_cs, a_pin_sclk, a_pin_copi}); end
    total++; if ({a_gnt, a_busy} !== 3'b000) begin bad++; $display("FAIL async_rst_gnt_busy got=%b exp=000", {a_gnt, a_busy}); end
    a_req = 2'b00; a_cs = 2'b11; a_sclk = 2'b00; a_copi = 2'b11;
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    a_req = 2'b11;
    tick();
    total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL simul_first got=%b exp=01", a_gnt); end
    a_cs[0] = 1'b0;
    tick();
    a_req[0] = 1'b0; a_cs[0] = 1'b1;
    tick();
    total++; if ({a_gnt, a_busy} !== 3'b001) begin bad++; $display("FAIL simul_release got=%b exp=001", {a_gnt, a_busy}); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if ({a_gnt, a_busy} !== 3'b001) begin bad++; $display("FAIL simul_gap%0d got=%b exp=001", i, {a_gnt, a_busy}); end
    end
    tick();
    total++; if ({a_gnt, a_busy} !== 3'b000) begin bad++; $display("FAIL simul_idle got=%b exp=000", {a_gnt, a_busy}); end
    tick();
    total++; if (a_gnt !== 2'b10) begin bad++; $display("FAIL simul_second got=%b exp=10", a_gnt); end
  endtask

  task automatic test_hold();
    int n;
    a_cs[1] = 1'b0;
    tick();
    a_req[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (a_gnt !== 2'b10) begin bad++; $display("FAIL hold_keep%0d got=%b exp=10", i, a_gnt); end
    end
    a_cs[1] = 1'b1;
    tick();
    total++; if (a_gnt !== 2'b00) begin bad++; $display("FAIL hold_drop got=%b exp=00", a_gnt); end
    n = 0;
    while (a_busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    total++; if (n !== 4) begin bad++; $display("FAIL hold_busy_len got=%0d exp=4", n); end
  endtask

  task automatic test_isolation();
    logic [3:0] vec [4];
    vec[0] = 4'b0000; vec[1] = 4'b1011; vec[2] = 4'b0110; vec[3] = 4'b1101;
    a_req = 2'b01;
    tick();
    total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL iso_gnt got=%b exp=01", a_gnt); end
    a_cs[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // vec bits: {sclk1/cs1 toggle, sclk0, copi0, cipo}
      a_sclk     = {vec[i][3], vec[i][2]};
      a_cs[1]    = vec[i][3];
      a_copi     = {~vec[i][1], vec[i][1]};
      a_pin_cipo = vec[i][0];
      #1;
      total++;
      if ({a_pin_cs, a_cipo, a_pin_sclk, a_pin_copi} !== {2'b10, 1'b1, vec[i][0], vec[i][2], vec[i][1]}) begin
        bad++;
        $display("FAIL iso_vec%0d got=%b exp=%b", i, {a_pin_cs, a_cipo, a_pin_sclk, a_pin_copi},
                 {2'b10, 1'b1, vec[i][0], vec[i][2], vec[i][1]});
      end
      tick();
    end
    a_req = 2'b00; a_cs = 2'b11; a_sclk = 2'b00; a_copi = 2'b11; a_pin_cipo = 1'b1;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_fairness();
    logic [1:0] expv;
    int         n;
    int         owner;
    expv = 2'b10;  // last owner was 0, so pointer sits at 1
    a_req = 2'b11;
    for (int g = 0; g < 20; g++) begin
      n = 0;
      while (a_gnt === 2'b00 && n < 20) begin
        n++;
        tick();
      end
      total++;
      if (a_gnt !== expv) begin
        bad++;
        $display("FAIL fair_grant%0d got=%b exp=%b", g, a_gnt, expv);
        break;
      end
      owner = (a_gnt == 2'b01) ? 0 : 1;
      a_cs[owner] = 1'b0;
      tick();
      a_cs[owner] = 1'b1; a_req[owner] = 1'b0;
      tick();
      a_req[owner] = 1'b1;
      expv = ~expv;
    end
    a_req = 2'b00; a_cs = 2'b11;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_watchdog();
    int n;
    b_req = 2'b01;
    tick();
    total++; if (b_gnt !== 2'b01) begin bad++; $display("FAIL wd_gnt got=%b exp=01", b_gnt); end
    b_cs[0] = 1'b0; b_req[1] = 1'b1;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      total++; if (b_timeout !== 1'b0) begin bad++; $display("FAIL wd_early_to cycle=%0d got=%b exp=0", n, b_timeout); break; end
      tick();
      if (b_gnt !== 2'b01) break;
      n++;
    end
    total++; if (n !== 16) begin bad++; $display("FAIL wd_hold_len got=%0d exp=16", n); end
    total++; if ({b_timeout, b_gnt, b_pin_cs} !== 5'b10011) begin bad++; $display("FAIL wd_fire got=%b exp=10011", {b_timeout, b_gnt, b_pin_cs}); end
    tick();
    total++; if (b_timeout !== 1'b0) begin bad++; $display("FAIL wd_pulse_len got=%b exp=0", b_timeout); end
    n = 1;
    while (b_gnt === 2'b00 && n < 20) begin
      n++;
      tick();
    end
    total++; if (b_gnt !== 2'b10 || n !== 5) begin bad++; $display("FAIL wd_next_owner got=%b after=%0d exp=10 after=5", b_gnt, n); end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_hold();
    test_isolation();
    test_fairness();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
